// File: rtl/nes_debugger_pkg.sv
// nes_debugger_pkg: value-ID map, step-controller states and STATUS bit layout
// shared by the debugger value controller and its step controller.
package nes_debugger_pkg;

  localparam int ID_NES_RESET_N = 1;
  localparam int ID_MEMORY_POOL = 2;
  localparam int ID_CPU_STEP    = 3;
  localparam int ID_CPU_RUN     = 4;
  localparam int ID_BP_ADDR     = 5;
  localparam int ID_BP_ENABLE   = 6;
  localparam int ID_STATUS      = 7;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_STEPPING = 2'd1,
    ST_RUNNING  = 2'd2
  } step_state_t;

  localparam int STATUS_HALTED_BIT   = 0;
  localparam int STATUS_STEPPING_BIT = 1;
  localparam int STATUS_RUNNING_BIT  = 2;
  localparam int STATUS_BP_HIT_BIT   = 3;

endpackage

// File: rtl/nes_debugger_step_ctrl.sv
// nes_debugger_step_ctrl: halt/step/run FSM, step counter and breakpoint unit.
// Breakpoint logic is present only when DEBUGGER_BREAKPOINT_EN is defined.
module nes_debugger_step_ctrl
  import nes_debugger_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int STEP_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_host_wr,
  input  logic              i_step_wr,
  input  logic              i_run_wr,
  input  logic              i_bp_addr_wr,
  input  logic              i_bp_enable_wr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_cpu_sync,
  input  logic [15:0]       i_cpu_address,
  output logic              o_halted,
  output logic              o_stepping,
  output logic              o_running,
  output logic [STEP_W-1:0] o_count,
  output logic              o_bp_hit,
  output logic [DATA_W-1:0] o_bp_addr,
  output logic [DATA_W-1:0] o_bp_enable,
  output logic              o_cpu_clk_en
);

  step_state_t       r_state;
  logic [STEP_W-1:0] r_count;
  logic              r_cpu_clk_en;
  logic              r_bp_hit;
  logic              r_skip;
  logic [STEP_W-1:0] w_step_n;
  logic              w_sync_act;
  logic              w_bp_match;

`ifdef DEBUGGER_BREAKPOINT_EN
  logic [DATA_W-1:0] r_bp_addr;
  logic [DATA_W-1:0] r_bp_enable;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bp_addr   <= '0;
      r_bp_enable <= '0;
    end else begin
      if (i_bp_addr_wr)   r_bp_addr   <= i_data;
      if (i_bp_enable_wr) r_bp_enable <= i_data;
    end
  end

  assign w_bp_match  = r_bp_enable[0] && (i_cpu_address == r_bp_addr[15:0]);
  assign o_bp_addr   = r_bp_addr;
  assign o_bp_enable = r_bp_enable;
`else
  logic w_unused_bp;

  assign w_unused_bp = ^{i_cpu_address, i_bp_addr_wr, i_bp_enable_wr, i_data};
  assign w_bp_match  = 1'b0;
  assign o_bp_addr   = '0;
  assign o_bp_enable = '0;
`endif

  assign w_step_n   = i_data[STEP_W-1:0];
  // Host writes win over a coincident sync; a halted CPU never consumes syncs.
  assign w_sync_act = i_cpu_sync && !i_host_wr && (r_state != ST_HALTED);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_RUNNING;
      r_count      <= '0;
      r_cpu_clk_en <= 1'b1;
      r_bp_hit     <= 1'b0;
      r_skip       <= 1'b0;
    end else if (i_run_wr) begin
      r_count  <= '0;
      r_bp_hit <= 1'b0;
      if (i_data[0]) begin
        r_state      <= ST_RUNNING;
        r_cpu_clk_en <= 1'b1;
      end else begin
        r_state      <= ST_HALTED;
        r_cpu_clk_en <= 1'b0;
      end
    end else if (i_step_wr) begin
      r_bp_hit <= 1'b0;
      if ((r_state == ST_HALTED) && (w_step_n != '0)) begin
        r_state      <= ST_STEPPING;
        r_count      <= w_step_n;
        r_cpu_clk_en <= 1'b1;
      end
    end else if (w_sync_act) begin
      // The sync right after a breakpoint halt re-fetches the breakpoint opcode.
      if (r_skip) begin
        r_skip <= 1'b0;
      end else if (w_bp_match) begin
        r_state      <= ST_HALTED;
        r_count      <= '0;
        r_cpu_clk_en <= 1'b0;
        r_bp_hit     <= 1'b1;
        r_skip       <= 1'b1;
      end else if (r_state == ST_STEPPING) begin
        r_count <= r_count - STEP_W'(1);
        if (r_count == STEP_W'(1)) begin
          r_state      <= ST_HALTED;
          r_cpu_clk_en <= 1'b0;
        end
      end
    end
  end

  assign o_halted     = (r_state == ST_HALTED);
  assign o_stepping   = (r_state == ST_STEPPING);
  assign o_running    = (r_state == ST_RUNNING);
  assign o_count      = r_count;
  assign o_bp_hit     = r_bp_hit;
  assign o_cpu_clk_en = r_cpu_clk_en;

endmodule

// File: rtl/nes_debugger_values_ctrl.sv
// nes_debugger_values_ctrl: host value-ID decode, NES reset/pool registers and
// registered read port. Breakpoint IDs are live only with DEBUGGER_BREAKPOINT_EN.
module nes_debugger_values_ctrl
  import nes_debugger_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ID_W   = 16,
  parameter int POOL_W = 2,
  parameter int STEP_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_ena,
  input  logic              i_wea,
  input  logic [ID_W-1:0]   i_id,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_nes_reset_n,
  output logic [POOL_W-1:0] o_debugger_memory_pool,
  output logic              o_cpu_clk_en,
  input  logic              i_cpu_sync,
  input  logic [15:0]       i_cpu_address
);

  logic              w_wr;
  logic              w_step_wr;
  logic              w_run_wr;
  logic              w_bp_addr_wr;
  logic              w_bp_enable_wr;
  logic              w_halted;
  logic              w_stepping;
  logic              w_running;
  logic              w_bp_hit;
  logic [STEP_W-1:0] w_count;
  logic [DATA_W-1:0] w_bp_addr;
  logic [DATA_W-1:0] w_bp_enable;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_rd_val;
  logic              r_nes_reset_n;
  logic [POOL_W-1:0] r_pool;
  logic [DATA_W-1:0] r_data;

  assign w_wr           = i_ena & i_wea;
  assign w_step_wr      = w_wr && (i_id == ID_W'(ID_CPU_STEP));
  assign w_run_wr       = w_wr && (i_id == ID_W'(ID_CPU_RUN));
  assign w_bp_addr_wr   = w_wr && (i_id == ID_W'(ID_BP_ADDR));
  assign w_bp_enable_wr = w_wr && (i_id == ID_W'(ID_BP_ENABLE));

  nes_debugger_step_ctrl #(
    .DATA_W(DATA_W),
    .STEP_W(STEP_W)
  ) u_step_ctrl (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_host_wr      (w_wr),
    .i_step_wr      (w_step_wr),
    .i_run_wr       (w_run_wr),
    .i_bp_addr_wr   (w_bp_addr_wr),
    .i_bp_enable_wr (w_bp_enable_wr),
    .i_data         (i_data),
    .i_cpu_sync     (i_cpu_sync),
    .i_cpu_address  (i_cpu_address),
    .o_halted       (w_halted),
    .o_stepping     (w_stepping),
    .o_running      (w_running),
    .o_count        (w_count),
    .o_bp_hit       (w_bp_hit),
    .o_bp_addr      (w_bp_addr),
    .o_bp_enable    (w_bp_enable),
    .o_cpu_clk_en   (o_cpu_clk_en)
  );

  always_comb begin
    w_status                      = '0;
    w_status[STATUS_HALTED_BIT]   = w_halted;
    w_status[STATUS_STEPPING_BIT] = w_stepping;
    w_status[STATUS_RUNNING_BIT]  = w_running;
    w_status[STATUS_BP_HIT_BIT]   = w_bp_hit;
  end

  always_comb begin
    w_rd_val = '0;
    case (i_id)
      ID_W'(ID_NES_RESET_N): w_rd_val = DATA_W'(r_nes_reset_n);
      ID_W'(ID_MEMORY_POOL): w_rd_val = DATA_W'(r_pool);
      ID_W'(ID_CPU_STEP):    w_rd_val = DATA_W'(w_count);
      ID_W'(ID_CPU_RUN):     w_rd_val = DATA_W'(w_running);
      ID_W'(ID_BP_ADDR):     w_rd_val = w_bp_addr;
      ID_W'(ID_BP_ENABLE):   w_rd_val = w_bp_enable;
      ID_W'(ID_STATUS):      w_rd_val = w_status;
      default:               w_rd_val = '0;
    endcase
  end

  // Read data is valid only for the cycle after a read strobe, otherwise zero.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_nes_reset_n <= 1'b1;
      r_pool        <= '0;
      r_data        <= '0;
    end else begin
      if (w_wr && (i_id == ID_W'(ID_NES_RESET_N))) r_nes_reset_n <= (i_data == DATA_W'(1));
      if (w_wr && (i_id == ID_W'(ID_MEMORY_POOL))) r_pool <= i_data[POOL_W-1:0];
      r_data <= (i_ena && !i_wea) ? w_rd_val : '0;
    end
  end

  assign o_data                 = r_data;
  assign o_nes_reset_n          = r_nes_reset_n;
  assign o_debugger_memory_pool = r_pool;

endmodule
